// File: rtl/cnv_pkg.sv
// Shared definitions for the convolution output-feature-map writer:
// frame geometry defaults, accumulator/quantization bit positions,
// the writer FSM state type and the per-channel quantize helper.
package cnv_pkg;

    localparam int WIDTH_DEF   = 128;
    localparam int HEIGHT_DEF  = 128;
    localparam int NUM_MAC_DEF = 16;

    localparam int ACC_W  = 20;
    localparam int Q_MSB  = 19;
    localparam int Q_LSB  = 12;
    localparam int Q_W    = Q_MSB - Q_LSB + 1;
    localparam int ADDR_W = 14;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Keep the top accumulator bits (signed truncation); with relu set,
    // negative accumulators clamp to zero.
    function automatic logic [Q_W-1:0] quantize(input logic [ACC_W-1:0] acc,
                                                 input logic             relu);
        logic [Q_W-1:0] q;
        q = acc[Q_MSB:Q_LSB];
        if (relu && acc[Q_MSB]) begin
            q = '0;
        end
        return q;
    endfunction

endpackage

// File: rtl/cnv_quant.sv
// Per-channel quantizer: 20-bit accumulator in, 8-bit pixel out, purely
// combinational. Build option CNV_OFM_RELU_EN clamps negative results to 0.
module cnv_quant
    import cnv_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    output logic [Q_W-1:0]   q
);

`ifdef CNV_OFM_RELU_EN
    // Negative accumulators are written as zero.
    assign q = quantize(acc, 1'b1);
`else
    // Plain truncation to the upper accumulator bits.
    assign q = quantize(acc, 1'b0);
`endif

endmodule

// File: rtl/cnv_ofm_writer.sv
// Output feature-map writer. Armed by start_i, it takes one MAC result
// beat per vld_i in raster order and issues a registered write of the
// quantized channels to the output buffer. vld_i outside a frame is a
// protocol error (sticky err_o, cleared by the next start_i).
// Build option: CNV_OFM_RELU_EN (ReLU clamp inside cnv_quant).
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start_i; vld_i is dropped and flags err_o
// ST_RUN  | accepting pixels; returns to idle after the last pixel
module cnv_ofm_writer
    import cnv_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int HEIGHT  = HEIGHT_DEF,
    parameter int NUM_MAC = NUM_MAC_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start_i,
    input  logic                     vld_i,
    input  logic [NUM_MAC*ACC_W-1:0] acc_i,
    output logic                     ofm_we_o,
    output logic [ADDR_W-1:0]        ofm_addr_o,
    output logic [NUM_MAC*Q_W-1:0]   ofm_wdata_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     err_o
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    state_t                   state;
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic                     accept;
    logic                     last_col;
    logic                     last_row;
    logic [ADDR_W-1:0]        pix_addr;
    logic [NUM_MAC*Q_W-1:0]   q_data;

    assign accept   = (state == ST_RUN) && vld_i;
    assign last_col = (col == COL_W'(WIDTH - 1));
    assign last_row = (row == ROW_W'(HEIGHT - 1));
    assign pix_addr = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);
    assign busy_o   = (state == ST_RUN);

    // One quantizer per MAC channel.
    for (genvar k = 0; k < NUM_MAC; k++) begin : g_quant
        cnv_quant u_quant (
            .acc (acc_i[k*ACC_W +: ACC_W]),
            .q   (q_data[k*Q_W +: Q_W])
        );
    end

    // Frame FSM and raster counters; start_i in RUN is ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state <= ST_RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                ST_RUN: begin
                    if (vld_i) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row   <= '0;
                                state <= ST_IDLE;
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error: a stray beat in idle wins over a same-cycle start_i.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_o <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (vld_i) begin
                err_o <= 1'b1;
            end else if (start_i) begin
                err_o <= 1'b0;
            end
        end
    end

    // Registered write port; address/data hold between writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ofm_we_o     <= 1'b0;
            ofm_addr_o   <= '0;
            ofm_wdata_o  <= '0;
            frame_done_o <= 1'b0;
        end else begin
            ofm_we_o     <= accept;
            frame_done_o <= accept && last_col && last_row;
            if (accept) begin
                ofm_addr_o  <= pix_addr;
                ofm_wdata_o <= q_data;
            end
        end
    end

endmodule

// File: tb/tb_cnv_ofm_writer.sv
// Self-checking bench for cnv_ofm_writer (default geometry 128x128, 16 MACs).
// Expected writes are queued when beats are driven and popped by a monitor
// that samples on the falling edge.
module tb_cnv_ofm_writer;

    localparam int NPIX = 128 * 128;
    localparam int NM   = 16;

    typedef struct {
        logic [19:0] acc;
        logic [7:0]  q;
    } vec_t;

    typedef struct {
        logic [13:0]   addr;
        logic [127:0]  data;
        logic          done;
    } exp_t;

    logic          clk;
    logic          rstn;
    logic          start_i;
    logic          vld_i;
    logic [319:0]  acc_i;
    logic          ofm_we_o;
    logic [13:0]   ofm_addr_o;
    logic [127:0]  ofm_wdata_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          err_o;

    vec_t   tbl [8];
    exp_t   sb [$];

    int     n_checks = 0;
    int     n_fail   = 0;
    int     wr_cnt   = 0;
    int     done_cnt = 0;
    logic   running  = 1'b0;
    logic   err_m    = 1'b0;
    int     pix      = 0;
    logic [13:0]  prev_addr = '0;
    logic [127:0] prev_data = '0;
    logic   relu;

    cnv_ofm_writer dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .vld_i        (vld_i),
        .acc_i        (acc_i),
        .ofm_we_o     (ofm_we_o),
        .ofm_addr_o   (ofm_addr_o),
        .ofm_wdata_o  (ofm_wdata_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and advance the reference model.
    task automatic drive(input logic st, input logic v, input int seed);
        exp_t e;
        logic [127:0] d;
        @(negedge clk);
        #1;
        start_i = st;
        vld_i   = v;
        d = '0;
        for (int k = 0; k < NM; k++) begin
            acc_i[k*20 +: 20] = tbl[(seed + k) % 8].acc;
            d[k*8 +: 8]       = tbl[(seed + k) % 8].q;
        end
        if (running) begin
            if (v) begin
                e.addr = 14'(pix);
                e.data = d;
                e.done = (pix == NPIX - 1);
                sb.push_back(e);
                pix++;
                if (pix == NPIX) begin
                    running = 1'b0;
                    pix     = 0;
                end
            end
        end else begin
            if (v) err_m = 1'b1;
            else if (st) err_m = 1'b0;
            if (st) begin
                running = 1'b1;
                pix     = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rstn    = 1'b0;
        start_i = 1'b0;
        vld_i   = 1'b0;
        #1;
        check("rst_we",    ofm_we_o,     0);
        check("rst_addr",  ofm_addr_o,   0);
        check("rst_data",  ofm_wdata_o,  0);
        check("rst_done",  frame_done_o, 0);
        check("rst_err",   err_o,        0);
        check("rst_busy",  busy_o,       0);
        check("rst_sb_empty", sb.size(), 0);
        running   = 1'b0;
        err_m     = 1'b0;
        pix       = 0;
        prev_addr = '0;
        prev_data = '0;
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor: scoreboard pop, hold behaviour, status flags against model.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            check("busy", busy_o, running);
            check("err",  err_o,  err_m);
            if (ofm_we_o) begin
                wr_cnt++;
                if (frame_done_o) done_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d written, no write expected", ofm_addr_o);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", ofm_addr_o,   e.addr);
                    check("wr_data", ofm_wdata_o,  e.data);
                    check("wr_done", frame_done_o, e.done);
                end
                if (prev_addr == 14'd127) check("row_wrap_addr", ofm_addr_o, 128);
                prev_addr = ofm_addr_o;
                prev_data = ofm_wdata_o;
            end else begin
                check("done_without_we", frame_done_o, 0);
                check("addr_hold", ofm_addr_o,  prev_addr);
                check("data_hold", ofm_wdata_o, prev_data);
            end
        end
    end

    initial begin
        int snap;
`ifdef CNV_OFM_RELU_EN
        relu = 1'b1;
`else
        relu = 1'b0;
`endif
        tbl[0] = '{20'h0A5FF, 8'h0A};
        tbl[1] = '{20'h12345, 8'h12};
        tbl[2] = '{20'h7FFFF, 8'h7F};
        tbl[3] = '{20'h80000, relu ? 8'h00 : 8'h80};
        tbl[4] = '{20'h00FFF, 8'h00};
        tbl[5] = '{20'hFFFFF, relu ? 8'h00 : 8'hFF};
        tbl[6] = '{20'h5A000, 8'h5A};
        tbl[7] = '{20'hFF000, relu ? 8'h00 : 8'hFF};

        rstn    = 1'b0;
        start_i = 1'b0;
        vld_i   = 1'b0;
        acc_i   = '0;
        do_reset();

        // Stray beats before any start: dropped, error set.
        repeat (3) drive(1'b0, 1'b1, 0);
        drive(1'b0, 1'b0, 0);
        check("stray_err_set", err_o, 1);
        check("stray_no_write", wr_cnt, 0);

        // start_i clears the error and enters RUN.
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        check("start_clears_err", err_o, 0);
        check("start_busy", busy_o, 1);

        // Full frame, back-to-back beats; start_i again at beat 100 is ignored.
        for (int b = 0; b < NPIX; b++) begin
            drive(b == 100, 1'b1, b % 8);
        end
        repeat (3) drive(1'b0, 1'b0, 0);
        check("f1_done_cnt", done_cnt, 1);
        check("f1_wr_cnt",   wr_cnt,   NPIX);
        check("f1_last_addr", prev_addr, NPIX - 1);
        check("f1_busy_low", busy_o, 0);
        check("f1_err_low",  err_o,  0);
        check("f1_sb_empty", sb.size(), 0);

        // Second frame: table-driven channel patterns, then abort by reset.
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, i);
            drive(1'b0, 1'b0, 0);
            check("tbl_byte0",  ofm_wdata_o[7:0],     tbl[i].q);
            check("tbl_byte15", ofm_wdata_o[127:120], tbl[(i + 15) % 8].q);
        end
        for (int b = 8; b < 500; b++) begin
            drive(1'b0, 1'b1, b % 8);
        end
        repeat (2) drive(1'b0, 1'b0, 0);
        snap = wr_cnt;
        do_reset();
        check("abort_no_done", done_cnt, 1);

        // Third frame: start with a same-cycle beat (dropped, error), then full frame with gaps.
        drive(1'b1, 1'b1, 0);
        drive(1'b0, 1'b0, 0);
        check("startvld_err",      err_o,  1);
        check("startvld_busy",     busy_o, 1);
        check("startvld_no_write", wr_cnt, snap);
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 0);
        check("f3_first_addr", ofm_addr_o, 0);
        check("f3_first_cnt",  wr_cnt, snap + 1);
        check("f3_no_old_done", done_cnt, 1);
        for (int b = 1; b < NPIX; b++) begin
            if (b % 37 == 0) drive(1'b1, 1'b0, 0);
            drive(1'b0, 1'b1, (b * 3) % 8);
        end
        repeat (3) drive(1'b0, 1'b0, 0);
        check("f3_done_cnt", done_cnt, 2);
        check("f3_busy_low", busy_o, 0);
        check("f3_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
